fft_norm_sched: RTL and testbench

FFT_NORM_SCHED -- requirements
Module: fft_norm_sched

---
 rtl/fft_norm_sched.sv | 136 +++++++++++++
 tb/tb_fft_norm_sched.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_norm_sched.sv
// Block-floating-point scheduler for a 64-point FFT: tracks per-frame sample headroom and
// hands the normalization unit its next left-shift code. Optional FFT64_OVF_BACKOFF_EN backs off by one on overflow.
module fft_norm_sched #(
    parameter int nb = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ED,
    input  logic          START_IN,
    input  logic [nb+2:0] DR,
    input  logic [nb+2:0] DI,
    input  logic          OVF_IN,
    output logic [1:0]    SHIFT,
    output logic          NSTART,
    output logic [1:0]    EXP_OUT,
    output logic          EXP_VLD,
    output logic          OVF_FLAG,
    output logic          BUSY
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [1:0] hmin_q, hmin_d;
    logic       fovf_q, fovf_d;
    logic [1:0] shift_q, shift_d;
    logic       nstart_q, nstart_d;
    logic [1:0] exp_out_q, exp_out_d;
    logic       exp_vld_q, exp_vld_d;
    logic       ovf_flag_q, ovf_flag_d;

    logic [1:0] h_re, h_im, hs, hmin_fold, code;
    logic       fovf_fold;

    // Count of redundant sign bits below the MSB, saturated at 3.
    function automatic logic [1:0] headroom(input logic [nb+2:0] x);
        if (x[nb+2] != x[nb+1]) return 2'd0;
        if (x[nb+2] != x[nb])   return 2'd1;
        if (x[nb+2] != x[nb-1]) return 2'd2;
        return 2'd3;
    endfunction

    always_comb begin
        h_re      = headroom(DR);
        h_im      = headroom(DI);
        hs        = (h_re < h_im) ? h_re : h_im;
        hmin_fold = (hs < hmin_q) ? hs : hmin_q;
        fovf_fold = fovf_q | OVF_IN;
        code      = hmin_fold;
`ifdef FFT64_OVF_BACKOFF_EN
        if (fovf_fold) code = (hmin_fold == 2'd0) ? 2'd0 : hmin_fold - 2'd1;
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hmin_d     = hmin_q;
        fovf_d     = fovf_q;
        shift_d    = shift_q;
        nstart_d   = nstart_q;
        exp_out_d  = exp_out_q;
        exp_vld_d  = exp_vld_q;
        ovf_flag_d = ovf_flag_q;
        if (ED) begin
            nstart_d  = 1'b0;
            exp_vld_d = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (START_IN) begin
                        state_d  = StRun;
                        cnt_d    = 6'd1;
                        hmin_d   = hs;
                        nstart_d = 1'b1;
                    end
                end
                StRun: begin
                    ovf_flag_d = ovf_flag_q | OVF_IN;
                    // Frame end takes priority over a coincident START_IN.
                    if (cnt_q == 6'd63) begin
                        shift_d   = code;
                        exp_out_d = shift_q;
                        exp_vld_d = 1'b1;
                        nstart_d  = 1'b1;
                        hmin_d    = 2'd3;
                        fovf_d    = 1'b0;
                        cnt_d     = 6'd0;
                    end else if (START_IN && (cnt_q != 6'd0)) begin
                        cnt_d    = 6'd1;
                        hmin_d   = hs;
                        fovf_d   = 1'b0;
                        nstart_d = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + 6'd1;
                        hmin_d = hmin_fold;
                        fovf_d = fovf_fold;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            cnt_q      <= 6'd0;
            hmin_q     <= 2'd3;
            fovf_q     <= 1'b0;
            shift_q    <= 2'd0;
            nstart_q   <= 1'b0;
            exp_out_q  <= 2'd0;
            exp_vld_q  <= 1'b0;
            ovf_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hmin_q     <= hmin_d;
            fovf_q     <= fovf_d;
            shift_q    <= shift_d;
            nstart_q   <= nstart_d;
            exp_out_q  <= exp_out_d;
            exp_vld_q  <= exp_vld_d;
            ovf_flag_q <= ovf_flag_d;
        end
    end

    assign SHIFT    = shift_q;
    assign NSTART   = nstart_q;
    assign EXP_OUT  = exp_out_q;
    assign EXP_VLD  = exp_vld_q;
    assign OVF_FLAG = ovf_flag_q;
    assign BUSY     = (state_q == StRun);

endmodule

// File: tb/tb_fft_norm_sched.sv
// Scoreboard bench for fft_norm_sched: a frame-level reference model queues expected outputs per
// ED-qualified edge, and an independent monitor compares them (and hold behaviour when ED is low).
module tb_fft_norm_sched;

    localparam int NB = 16;
    localparam int W  = NB + 3;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         ED = 1'b0, START_IN = 1'b0, OVF_IN = 1'b0;
    logic [W-1:0] DR = '0, DI = '0;
    logic [1:0]   SHIFT, EXP_OUT;
    logic         NSTART, EXP_VLD, OVF_FLAG, BUSY;

    fft_norm_sched #(.nb(NB)) dut (
        .CLK(CLK), .RST(RST), .ED(ED), .START_IN(START_IN), .DR(DR), .DI(DI), .OVF_IN(OVF_IN),
        .SHIFT(SHIFT), .NSTART(NSTART), .EXP_OUT(EXP_OUT), .EXP_VLD(EXP_VLD),
        .OVF_FLAG(OVF_FLAG), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       nstart;
        logic       vld;
        logic [1:0] shift;
        logic [1:0] exp_out;
        logic       ovf;
        logic       busy;
    } obs_t;

    obs_t exp_q[$];
    obs_t last_exp = '0;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;

    // Reference model state: whole-frame view of headroom values.
    bit m_run;
    int m_pos;
    int m_hs[$];
    bit m_fovf;
    int m_shift, m_exp_out;
    bit m_ovf_flag;

    function automatic obs_t observe();
        return {NSTART, EXP_VLD, SHIFT, EXP_OUT, OVF_FLAG, BUSY};
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s @%0t: got %b required %b (nstart,vld,shift,exp_out,ovf,busy)",
                     name, $time, act, req);
        end
    endtask

    function automatic int hroom(input logic [W-1:0] x);
        int n = 0;
        for (int k = 1; k <= 3; k++) begin
            if (x[W-1-k] != x[W-1]) break;
            n = k;
        end
        return n;
    endfunction

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_hs.delete(); m_fovf = 0;
        m_shift = 0; m_exp_out = 0; m_ovf_flag = 0;
    endtask

    task automatic model_step(input bit st, input logic [W-1:0] dr, input logic [W-1:0] di,
                              input bit ov);
        int   hs, code;
        obs_t o;
        hs = (hroom(dr) < hroom(di)) ? hroom(dr) : hroom(di);
        o  = '0;
        if (!m_run) begin
            if (st) begin
                m_run = 1; m_hs.delete(); m_hs.push_back(hs); m_fovf = 0; m_pos = 1;
                o.nstart = 1;
            end
        end else begin
            m_ovf_flag |= ov;
            if (m_pos == 63) begin
                m_hs.push_back(hs);
                m_fovf |= ov;
                code = 3;
                foreach (m_hs[i]) if (m_hs[i] < code) code = m_hs[i];
`ifdef FFT64_OVF_BACKOFF_EN
                if (m_fovf && code > 0) code--;
`endif
                m_exp_out = m_shift;
                m_shift   = code;
                o.vld = 1; o.nstart = 1;
                m_hs.delete(); m_fovf = 0; m_pos = 0;
            end else if (st && m_pos != 0) begin
                m_hs.delete(); m_hs.push_back(hs); m_fovf = 0; m_pos = 1;
                o.nstart = 1;
            end else begin
                m_hs.push_back(hs);
                m_fovf |= ov;
                m_pos++;
            end
        end
        o.shift   = 2'(m_shift);
        o.exp_out = 2'(m_exp_out);
        o.ovf     = m_ovf_flag;
        o.busy    = m_run;
        exp_q.push_back(o);
    endtask

    task automatic step(input bit ed, input bit st, input logic [W-1:0] dr,
                        input logic [W-1:0] di, input bit ov);
        @(negedge CLK);
        ED = ed; START_IN = st; DR = dr; DI = di; OVF_IN = ov;
        if (ed) model_step(st, dr, di, ov);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        chk_en = 0;
        ED = 0; START_IN = 0; OVF_IN = 0; DR = '0; DI = '0;
        #2 RST = 1;
        #1 check("async_reset", observe(), '0);
        exp_q.delete();
        model_reset();
        last_exp = '0;
        @(negedge CLK);
        RST = 0;
        #1 chk_en = 1;
    endtask

    // Random sample whose significant width (and so headroom) varies.
    function automatic logic [W-1:0] rnd_sample();
        logic [W-1:0] x;
        int bits, sel;
        x   = W'($urandom);
        sel = $urandom_range(0, 199);
        bits = (sel < 170) ? 16 : (sel < 193) ? 17 : (sel < 199) ? 18 : 19;
        for (int i = bits; i < W; i++) x[i] = x[bits-1];
        return x;
    endfunction

    // Monitor: one expectation consumed per ED-qualified edge; otherwise outputs must hold.
    initial begin
        bit   edge_seen;
        obs_t cur;
        forever begin
            @(posedge CLK);
            edge_seen = ED && !RST;
            @(negedge CLK);
            if (chk_en) begin
                if (edge_seen) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL scoreboard_underflow @%0t: got edge, required queued entry",
                                 $time);
                    end else begin
                        cur = exp_q.pop_front();
                        check("ed_edge", observe(), cur);
                        last_exp = cur;
                    end
                end else begin
                    check("ed_low_hold", observe(), last_exp);
                end
            end
        end
    end

    initial begin
        do_reset();
        // All-zero frame: SHIFT becomes 3, EXP_OUT reports the initial 0.
        step(1, 1, '0, '0, 0);
        repeat (63) step(1, 0, '0, '0, 0);
        // Back-to-back frames with a single limiting sample.
        for (int i = 0; i < 64; i++) step(1, 0, (i == 10) ? 19'h08000 : 19'h0, '0, 0);
        for (int i = 0; i < 64; i++) step(1, 0, '0, (i == 10) ? 19'h20000 : 19'h0, 0);
        // Overflow at sample 5.
        for (int i = 0; i < 64; i++) step(1, 0, '0, '0, i == 5);
        // Abort at cnt 30, then a full frame from the restart.
        for (int i = 0; i < 30; i++) step(1, 0, 19'h7ffff, '0, 0);
        step(1, 1, '0, '0, 0);
        repeat (63) step(1, 0, '0, '0, 0);
        // START_IN on the frame-end edge is ignored.
        for (int i = 0; i < 64; i++) step(1, i == 63, '0, '0, 0);
        // ED alternating: pulses stretch across the idle clocks.
        for (int i = 0; i < 64; i++) begin
            step(1, 0, (i == 20) ? 19'h7c000 : 19'h0, '0, 0);
            step(0, 0, '0, '0, 0);
        end
        // Reach SHIFT=2, then reset at cnt 40.
        for (int i = 0; i < 64; i++) step(1, 0, (i == 10) ? 19'h08000 : 19'h0, '0, 0);
        repeat (40) step(1, 0, '0, '0, 0);
        do_reset();
        repeat (5) step(1, 0, '0, '0, 0);
        // Randomised traffic with one mid-run reset.
        for (int c = 0; c < 4000; c++) begin
            bit ed, st, ov;
            if (c == 2000) do_reset();
            ed = (c == 0 || c == 2000) ? 1'b1 : ($urandom_range(0, 3) != 0);
            st = (c == 0 || c == 2000) ? 1'b1 : ($urandom_range(0, 149) == 0);
            ov = ($urandom_range(0, 59) == 0);
            step(ed, st, rnd_sample(), rnd_sample(), ov);
        end
        repeat (3) step(0, 0, '0, '0, 0);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
